// File: rtl/relu_pool_pkg.sv
// Shared definitions for the relu_pool_stream pooling stage: mode encoding and the
// per-lane reduce used by both pooling stages.
package relu_pool_pkg;

  localparam logic MODE_MAX = 1'b0;
  localparam logic MODE_AVG = 1'b1;

  // Wide enough for DATA_W up to 64 plus two bits of sum growth.
  localparam int unsigned RED_W = 66;
  typedef logic signed [RED_W-1:0] red_t;

  // Callers sign-extend operands to red_t and keep only the bits they need.
  function automatic red_t lane_reduce(input red_t a, input red_t b, input logic mode);
    if (mode == MODE_AVG) begin
      return a + b;
    end
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// One-read one-write synchronous RAM holding the horizontal partial results of an even row.
// Read data is registered and holds until the next read.
module pool_line_buf #(
  parameter int unsigned DEPTH = 109,
  parameter int unsigned WIDTH = 33,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/relu_pool_stream.sv
// Streaming 2x2 stride-2 max/average pooling over CH lanes of raster-order pixels.
// Define RELU_POOL_RELU_EN to clamp negative input lanes to zero before pooling.
module relu_pool_stream
  import relu_pool_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CH     = 1,
  parameter int unsigned IMG_W  = 218,
  parameter int unsigned IMG_H  = 218
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  input  logic                 sof_in,
  input  logic                 mode_in,
  input  logic [CH*DATA_W-1:0] data_in,
  output logic                 valid_out,
  output logic [CH*DATA_W-1:0] data_out,
  output logic                 frame_done
);

  localparam int unsigned CW    = $clog2(IMG_W);
  localparam int unsigned RW    = $clog2(IMG_H);
  localparam int unsigned DEPTH = IMG_W / 2;
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned BW    = DATA_W + 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_FD   = CW'((IMG_W / 2) * 2 - 1);
  localparam logic [RW-1:0] ROW_FD   = RW'((IMG_H / 2) * 2 - 1);
  localparam bit            W_ODD    = (IMG_W % 2) == 1;
  localparam bit            H_ODD    = (IMG_H % 2) == 1;

  logic [CW-1:0]        col_q, col_e, col_n;
  logic [RW-1:0]        row_q, row_e, row_n;
  logic                 mode_q;
  logic [CH*DATA_W-1:0] h_q, x, res;
  logic [CH*BW-1:0]     hp, rd_data;
  logic                 first_px, keep, even_px, odd_px, wr_en, fire;
  logic [AW-1:0]        addr;

  always_comb begin
    col_e = sof_in ? '0 : col_q;
    row_e = sof_in ? '0 : row_q;
    col_n = col_e + 1'b1;
    row_n = row_e;
    if (col_e == COL_LAST) begin
      col_n = '0;
      row_n = (row_e == ROW_LAST) ? '0 : row_e + 1'b1;
    end
    first_px = (col_e == '0) && (row_e == '0);
    // Trailing odd column/row never completes a window.
    keep     = !(W_ODD && (col_e == COL_LAST)) && !(H_ODD && (row_e == ROW_LAST));
    even_px  = valid_in && keep && !col_e[0];
    odd_px   = valid_in && keep && col_e[0];
    wr_en    = odd_px && !row_e[0];
    fire     = odd_px && row_e[0];
    addr     = AW'(col_e >> 1);
  end

  for (genvar k = 0; k < CH; k++) begin : g_lane
    logic signed [DATA_W-1:0] x_l;
    red_t                     hp_r, out_r;
    logic                     unused_hi;

    always_comb begin
      x_l = data_in[k*DATA_W +: DATA_W];
`ifdef RELU_POOL_RELU_EN
      if (x_l < 0) begin
        x_l = '0;
      end
`endif
    end

    assign hp_r  = lane_reduce(red_t'($signed(h_q[k*DATA_W +: DATA_W])), red_t'(x_l), mode_q);
    assign out_r = lane_reduce(red_t'($signed(rd_data[k*BW +: BW])),
                               red_t'($signed(hp_r[BW-1:0])), mode_q);

    assign x[k*DATA_W +: DATA_W] = x_l;
    assign hp[k*BW +: BW]        = hp_r[BW-1:0];
    // Bits [DATA_W+1:2] are the DATA_W+2 bit sum shifted right by two, truncated.
    assign res[k*DATA_W +: DATA_W] = (mode_q == MODE_AVG) ? out_r[DATA_W+1:2]
                                                          : out_r[DATA_W-1:0];
    assign unused_hi = ^{hp_r[RED_W-1:BW], out_r[RED_W-1:DATA_W+2]};
  end

  pool_line_buf #(
    .DEPTH (DEPTH),
    .WIDTH (CH * BW)
  ) u_line_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (addr),
    .wr_data (hp),
    .rd_en   (even_px),
    .rd_addr (addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q      <= '0;
      row_q      <= '0;
      mode_q     <= MODE_MAX;
      h_q        <= '0;
      valid_out  <= 1'b0;
      data_out   <= '0;
      frame_done <= 1'b0;
    end else begin
      valid_out  <= fire;
      frame_done <= fire && (row_e == ROW_FD) && (col_e == COL_FD);
      if (valid_in) begin
        col_q <= col_n;
        row_q <= row_n;
        if (first_px) begin
          mode_q <= mode_in;
        end
      end
      if (even_px) begin
        h_q <= x;
      end
      if (fire) begin
        data_out <= res;
      end
    end
  end

endmodule

// File: tb/tb_relu_pool_stream.sv
// Scoreboard bench for relu_pool_stream: a 3-lane 16-bit 4x4 instance and a 1-lane
// 32-bit 5x3 instance, driven with directed frames whose results are precomputed.
module tb_relu_pool_stream;
  import relu_pool_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;

  logic        a_valid = 1'b0, a_sof = 1'b0, a_mode = 1'b0;
  logic [47:0] a_din = '0;
  logic        a_vout, a_fd;
  logic [47:0] a_dout;

  logic        b_valid = 1'b0, b_sof = 1'b0, b_mode = 1'b0;
  logic [31:0] b_din = '0;
  logic        b_vout, b_fd;
  logic [31:0] b_dout;

  logic [48:0] qa[$];
  logic [32:0] qb[$];
  logic [48:0] ea;
  logic [32:0] eb;
  int n_vec = 0;
  int n_bad = 0;

  relu_pool_stream #(.DATA_W(16), .CH(3), .IMG_W(4), .IMG_H(4)) u_dut_a (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (a_valid),
    .sof_in     (a_sof),
    .mode_in    (a_mode),
    .data_in    (a_din),
    .valid_out  (a_vout),
    .data_out   (a_dout),
    .frame_done (a_fd)
  );

  relu_pool_stream #(.DATA_W(32), .CH(1), .IMG_W(5), .IMG_H(3)) u_dut_b (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (b_valid),
    .sof_in     (b_sof),
    .mode_in    (b_mode),
    .data_in    (b_din),
    .valid_out  (b_vout),
    .data_out   (b_dout),
    .frame_done (b_fd)
  );

  function automatic logic [15:0] rl(input logic [15:0] v);
`ifdef RELU_POOL_RELU_EN
    return v[15] ? 16'h0000 : v;
`else
    return v;
`endif
  endfunction

  task automatic push_a(input int l0, input int l1, input int l2, input bit fd);
    qa.push_back({fd, rl(16'(l2)), rl(16'(l1)), rl(16'(l0))});
  endtask

  task automatic push_b(input int v, input bit fd);
    qb.push_back({fd, 32'(v)});
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the head of its queue; stray frame_done is an error.
  always @(negedge clk) begin
    if (!rst) begin
      if (a_vout) begin
        n_vec++;
        if (qa.size() == 0) begin
          n_bad++;
          $display("FAIL a_extra: got fd %b data %h, required no output", a_fd, a_dout);
        end else begin
          ea = qa.pop_front();
          if ({a_fd, a_dout} !== ea) begin
            n_bad++;
            $display("FAIL a_out: got fd %b data %h, required fd %b data %h",
                     a_fd, a_dout, ea[48], ea[47:0]);
          end
        end
      end else if (a_fd) begin
        n_vec++;
        n_bad++;
        $display("FAIL a_fd_alone: got frame_done 1, required 0");
      end
      if (b_vout) begin
        n_vec++;
        if (qb.size() == 0) begin
          n_bad++;
          $display("FAIL b_extra: got fd %b data %h, required no output", b_fd, b_dout);
        end else begin
          eb = qb.pop_front();
          if ({b_fd, b_dout} !== eb) begin
            n_bad++;
            $display("FAIL b_out: got fd %b data %h, required fd %b data %h",
                     b_fd, b_dout, eb[32], eb[31:0]);
          end
        end
      end else if (b_fd) begin
        n_vec++;
        n_bad++;
        $display("FAIL b_fd_alone: got frame_done 1, required 0");
      end
    end
  end

  // All drive tasks start and end 1 time unit after a rising edge.
  task automatic pix_a(input logic [15:0] l0, input logic [15:0] l1, input logic [15:0] l2,
                       input logic sof, input logic mode);
    a_valid = 1'b1;
    a_sof   = sof;
    a_mode  = mode;
    a_din   = {l2, l1, l0};
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    a_sof   = 1'b0;
    a_mode  = ~mode;
    a_din   = '0;
  endtask

  // Lane0 = p, lane1 = -p, lane2 = 7FFF for rows 0-1 and 8000 for rows 2-3.
  // mode_in is inverted after the first pixel to show it is only sampled at frame start.
  task automatic ramp_a(input logic mode, input logic sof, input int n);
    for (int p = 0; p < n; p++) begin
      pix_a(16'(p), 16'(-p), (p < 8) ? 16'h7FFF : 16'h8000, sof && (p == 0),
            (p == 0) ? mode : ~mode);
    end
  endtask

  // Every window is {-3,-5,-1,-7} on lane0 and {3,5,1,7} on lane1; lane2 is zero.
  task automatic pat_a(input logic mode);
    for (int p = 0; p < 16; p++) begin
      int r, c, v;
      r = p / 4;
      c = p % 4;
      if (r % 2 == 0) v = (c % 2 == 0) ? 3 : 5;
      else            v = (c % 2 == 0) ? 1 : 7;
      pix_a(16'(-v), 16'(v), 16'h0000, p == 0, (p == 0) ? mode : ~mode);
    end
  endtask

  task automatic ramp_b(input logic mode, input bit gap);
    for (int p = 0; p < 15; p++) begin
      b_valid = 1'b1;
      b_sof   = (p == 0);
      b_mode  = (p == 0) ? mode : ~mode;
      b_din   = 32'(p);
      @(posedge clk);
      #1;
      b_valid = 1'b0;
      b_sof   = 1'b0;
      b_din   = '0;
      if (gap) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_a", 64'({a_vout, a_fd, a_dout}), 64'd0);
    check("reset_b", 64'({b_vout, b_fd, b_dout}), 64'd0);
    rst = 1'b0;

    // Max and average over the ramp frame.
    push_a(5, 0, 32767, 0);  push_a(7, -2, 32767, 0);
    push_a(13, -8, -32768, 0); push_a(15, -10, -32768, 1);
    ramp_a(MODE_MAX, 1'b1, 16);
    push_a(2, -3, 32767, 0);  push_a(4, -5, 32767, 0);
    push_a(10, -11, -32768, 0); push_a(12, -13, -32768, 1);
    ramp_a(MODE_AVG, 1'b1, 16);

    // Negative window: average -16 >>> 2 = -4, max -1.
    for (int i = 0; i < 4; i++) push_a(-4, 4, 0, i == 3);
    pat_a(MODE_AVG);
    for (int i = 0; i < 4; i++) push_a(-1, 7, 0, i == 3);
    pat_a(MODE_MAX);

    // Partial frame abandoned by a mid-frame sof: counters sit at row 1, col 1.
    ramp_a(MODE_AVG, 1'b1, 5);
    push_a(5, 0, 32767, 0);  push_a(7, -2, 32767, 0);
    push_a(13, -8, -32768, 0); push_a(15, -10, -32768, 1);
    ramp_a(MODE_MAX, 1'b1, 16);

    // Partial frame abandoned by reset; next frame has no sof.
    ramp_a(MODE_MAX, 1'b1, 5);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_a", 64'({a_vout, a_fd, a_dout}), 64'd0);
    push_a(2, -3, 32767, 0);  push_a(4, -5, 32767, 0);
    push_a(10, -11, -32768, 0); push_a(12, -13, -32768, 1);
    ramp_a(MODE_AVG, 1'b0, 16);

    // Odd geometry: column 4 and row 2 never contribute.
    push_b(6, 0); push_b(8, 1);
    ramp_b(MODE_MAX, 1'b0);
    push_b(6, 0); push_b(8, 1);
    ramp_b(MODE_MAX, 1'b1);
    push_b(3, 0); push_b(5, 1);
    ramp_b(MODE_AVG, 1'b1);

    for (int i = 0; i < 20 && (qa.size() != 0 || qb.size() != 0); i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check("drain_a", 64'(qa.size()), 64'd0);
    check("drain_b", 64'(qb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
